stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/stopwatch_ctrl_if.sv | 27 ++
 rtl/stopwatch_ctrl_debounce.sv | 46 ++++
 rtl/stopwatch_ctrl.sv | 90 +++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared FSM state type, default timing
// constants and a counter-width helper for stopwatch_ctrl.
package stopwatch_pkg;

  localparam int TICK_DIV_DEF        = 1000000;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  // Width of a counter that must hold 0..n-1 (n >= 2).
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: raw buttons in, count/clear/run
// status out, as seen by the stopwatch control block.
interface stopwatch_ctrl_if;

  logic btn_start_stop;
  logic btn_clear;
  logic enable;
  logic clear;
  logic running;

  modport master (
    output btn_start_stop,
    output btn_clear,
    input  enable,
    input  clear,
    input  running
  );

  modport slave (
    input  btn_start_stop,
    input  btn_clear,
    output enable,
    output clear,
    output running
  );

endinterface

// File: rtl/stopwatch_ctrl_debounce.sv
// button_debounce: two-flop synchroniser, stability counter
// and one-cycle press pulse on an accepted 0->1 change.
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int W = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]   sync;
  logic         stable;
  logic         stable_q;
  logic [W-1:0] cnt;

  // Counter only runs while the synced level disagrees
  // with the accepted level; any agreement restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync     <= {sync[0], btn};
      stable_q <= stable;
      press    <= stable & ~stable_q;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt    <= '0;
        stable <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced start/stop + clear buttons
// drive an IDLE/RUN/PAUSE FSM and a tick prescaler.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV        = TICK_DIV_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic             clk,
  input logic             rst,
  stopwatch_ctrl_if.slave bus
);

  localparam int PW = cnt_w(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  sw_state_t     state;
  logic [PW-1:0] pre;
  logic          enable_q;
  logic          clear_q;
  logic          ss_press;
  logic          clr_press;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_ss (
    .clk  (clk),
    .rst  (rst),
    .btn  (bus.btn_start_stop),
    .press(ss_press)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_clr (
    .clk  (clk),
    .rst  (rst),
    .btn  (bus.btn_clear),
    .press(clr_press)
  );

  // Prescaler advances on every RUN cycle, including the
  // one that leaves RUN, so a wrap there still ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pre      <= '0;
      enable_q <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      enable_q <= 1'b0;
      clear_q  <= 1'b0;
      if (state == RUN) begin
        enable_q <= (pre == PRE_LAST);
        pre      <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
      end
      unique case (1'b1)
        (state == IDLE): begin
          if (clr_press) begin
            clear_q <= 1'b1;
            pre     <= '0;
          end else if (ss_press) begin
            state <= RUN;
          end
        end
        (state == RUN): begin
          if (ss_press) state <= PAUSE;
        end
        (state == PAUSE): begin
          if (clr_press) begin
            state   <= IDLE;
            clear_q <= 1'b1;
            pre     <= '0;
          end else if (ss_press) begin
            state <= RUN;
          end
        end
        default: begin
          state <= IDLE;
          pre   <= '0;
        end
      endcase
    end
  end

  assign bus.enable  = enable_q;
  assign bus.clear   = clear_q;
  assign bus.running = (state == RUN);

endmodule
